// File: rtl/ct_spsram_shadow_pkg.sv
// Shared types and helpers for the taint-shadowed single-port SRAM.
package ct_spsram_shadow_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Write-enable group that owns data bit b when each enable covers g bits.
  function automatic int grp_idx(input int b, input int g);
    return b / g;
  endfunction

endpackage

// File: rtl/ct_spsram_shadow_array.sv
// DEPTH x DW bit-write storage; optional low-priority clear port zeroes one entry.
module ct_spsram_shadow_array #(
  parameter int AW = 8,
  parameter int DW = 196
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] bwe_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (|bwe_i)
      mem_q[addr_i] <= (mem_q[addr_i] & ~bwe_i) | (wdata_i & bwe_i);
    else if (clr_en_i)
      mem_q[clr_addr_i] <= '0;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ct_spsram_shadow.sv
// Single-port SRAM with a per-bit taint shadow array, clear sweep after reset,
// and sticky flags for dropped shadow writes and tainted-address writes.
module ct_spsram_shadow
  import ct_spsram_shadow_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 196,
  parameter int WE_WIDTH   = 196,
  parameter int OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN,
  input  logic                  CEN_t0,
  input  logic                  GWEN,
  input  logic                  GWEN_t0,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [WE_WIDTH-1:0]   WEN_t0,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  CLR_BUSY,
  output logic                  CLR_VIOL,
  output logic                  ATAINT_WR
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int G     = DATA_WIDTH / WE_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  logic [DATA_WIDTH-1:0] wen_b, wen_t0_b;
  logic [DATA_WIDTH-1:0] d_bwe, d_rdata, sh_bwe_req, sh_bwe, sh_wdata, sh_rdata;
  logic [DATA_WIDTH-1:0] q1_q, q1_d, qt1_q, qt1_d;
  logic                  wr, rd, ctl_t, a_t, clearing, clr_en;
  logic                  viol_q, viol_d, atw_q, atw_d;
  clr_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    localparam int GI = grp_idx(b, G);
    assign wen_b[b]    = WEN[GI];
    assign wen_t0_b[b] = WEN_t0[GI];
  end

  assign wr       = !CEN && !GWEN;
  assign rd       = !CEN && GWEN;
  assign ctl_t    = CEN_t0 || GWEN_t0;
  assign a_t      = |A_t0;
  assign clearing = (state_q == CLEAR);

  assign d_bwe = {DATA_WIDTH{wr}} & ~wen_b;

  // Tainted controls widen the shadow write: a tainted group enable writes its
  // group, a tainted CEN/GWEN outside a write poisons the whole entry.
  assign sh_bwe_req = wr ? (~wen_b | wen_t0_b) : {DATA_WIDTH{ctl_t}};
  assign sh_bwe     = clearing ? '0 : sh_bwe_req;
  assign sh_wdata   = D_t0 | wen_t0_b | {DATA_WIDTH{ctl_t | a_t}};

  ct_spsram_shadow_array #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_data (
    .clk_i(CLK), .addr_i(A), .bwe_i(d_bwe), .wdata_i(D), .rdata_o(d_rdata),
    .clr_en_i(1'b0), .clr_addr_i('0)
  );

  ct_spsram_shadow_array #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_shadow (
    .clk_i(CLK), .addr_i(A), .bwe_i(sh_bwe), .wdata_i(sh_wdata), .rdata_o(sh_rdata),
    .clr_en_i(clr_en), .clr_addr_i(cnt_q[ADDR_WIDTH-1:0])
  );

  // Clear FSM
  always_ff @(posedge CLK) begin
    if (!cpurst_b) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DEPTH - 1)) state_d = READY;
      end
      default: ;
    endcase
  end

  always_comb begin
    clr_en = 1'b0;
    case (state_q)
      CLEAR:   clr_en = 1'b1;
      default: ;
    endcase
  end

  assign CLR_BUSY = clr_en;

  assign viol_d = viol_q | (clearing & (|sh_bwe_req));
  assign atw_d  = atw_q | (wr & a_t);

  always_comb begin
    q1_d  = q1_q;
    qt1_d = qt1_q;
    if (rd) begin
      q1_d  = d_rdata;
      qt1_d = clearing ? ONES : (sh_rdata | {DATA_WIDTH{a_t | ctl_t | atw_q}});
    end
  end

  always_ff @(posedge CLK) begin
    if (!cpurst_b) begin
      q1_q   <= '0;
      qt1_q  <= '0;
      viol_q <= 1'b0;
      atw_q  <= 1'b0;
    end else begin
      q1_q   <= q1_d;
      qt1_q  <= qt1_d;
      viol_q <= viol_d;
      atw_q  <= atw_d;
    end
  end

  assign CLR_VIOL  = viol_q;
  assign ATAINT_WR = atw_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] q2_q, qt2_q;
    always_ff @(posedge CLK) begin
      if (!cpurst_b) begin
        q2_q  <= '0;
        qt2_q <= '0;
      end else begin
        q2_q  <= q1_q;
        qt2_q <= qt1_q;
      end
    end
    assign Q    = q2_q;
    assign Q_t0 = qt2_q;
  end else begin : g_noreg
    assign Q    = q1_q;
    assign Q_t0 = qt1_q;
  end

endmodule
